// File: rtl/parking_pkg.sv
// parking_pkg: gate FSM state enum and filtered sensor-pair encodings {outer, inner}
package parking_pkg;
  typedef enum logic [2:0] {IDLE, IN_1, IN_2, IN_3, OUT_1, OUT_2, OUT_3, ERR} gate_state_t;
  localparam logic [1:0] CLEAR      = 2'b00;
  localparam logic [1:0] OUTER_ONLY = 2'b10;
  localparam logic [1:0] INNER_ONLY = 2'b01;
  localparam logic [1:0] BOTH       = 2'b11;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser plus debounce filter for one beam sensor
// ports: clk, reset (async high), raw (asynchronous beam input), filtered (clean level)
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync     <= '0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filtered) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= sync[1];
        cnt      <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/parking_gate_detector.sv
// parking_gate_detector: debounced two-beam gate direction detector emitting enter/exit/error pulses
// ports: clk, reset (async high), sensor_outer/sensor_inner (raw beams), car_enter/car_exit/seq_error (1-cycle pulses), busy
module parking_gate_detector
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_outer,
  input  logic sensor_inner,
  output logic car_enter,
  output logic car_exit,
  output logic seq_error,
  output logic busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic          o, i;
  logic [1:0]    pair;
  gate_state_t   state, legal, nxt;
  logic [TW-1:0] tcnt;
  logic          in_progress, timeout, enter_d, exit_d, err_d;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer (
    .clk(clk), .reset(reset), .raw(sensor_outer), .filtered(o)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner (
    .clk(clk), .reset(reset), .raw(sensor_inner), .filtered(i)
  );

  assign pair        = {o, i};
  assign in_progress = (state != IDLE) && (state != ERR);
  assign timeout     = in_progress && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      seq_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt;
      tcnt      <= (nxt != state || !in_progress) ? '0 : tcnt + 1'b1;
      car_enter <= enter_d;
      car_exit  <= exit_d;
      seq_error <= err_d;
      busy      <= nxt != IDLE;
    end

  // a real transition on the timeout edge takes priority over the timeout
  always_comb begin
    legal = state;
    case (state)
      IDLE:  legal = pair == OUTER_ONLY ? IN_1  : pair == INNER_ONLY ? OUT_1 : pair == BOTH       ? ERR  : IDLE;
      IN_1:  legal = pair == BOTH       ? IN_2  : pair == INNER_ONLY ? IN_3  : pair == CLEAR      ? IDLE : IN_1;
      IN_2:  legal = pair == INNER_ONLY ? IN_3  : pair == OUTER_ONLY ? IN_1  : pair == CLEAR      ? ERR  : IN_2;
      IN_3:  legal = pair == CLEAR      ? IDLE  : pair == BOTH       ? IN_2  : pair == OUTER_ONLY ? ERR  : IN_3;
      OUT_1: legal = pair == BOTH       ? OUT_2 : pair == OUTER_ONLY ? OUT_3 : pair == CLEAR      ? IDLE : OUT_1;
      OUT_2: legal = pair == OUTER_ONLY ? OUT_3 : pair == INNER_ONLY ? OUT_1 : pair == CLEAR      ? ERR  : OUT_2;
      OUT_3: legal = pair == CLEAR      ? IDLE  : pair == BOTH       ? OUT_2 : pair == INNER_ONLY ? ERR  : OUT_3;
      ERR:   legal = pair == CLEAR      ? IDLE  : ERR;
      default: legal = IDLE;
    endcase
    nxt = (legal == state && timeout) ? ERR : legal;
  end

  always_comb begin
    enter_d = state == IN_3  && nxt == IDLE;
    exit_d  = state == OUT_3 && nxt == IDLE;
    err_d   = state != ERR   && nxt == ERR;
  end
endmodule

// File: doc/parking_gate_detector.md
# parking_gate_detector

Front-end stage of the car-park controller. It turns two raw infrared beam sensors at the gate into clean single-cycle `car_enter` / `car_exit` pulses for the occupancy counter that sits directly downstream. Each sensor is synchronised and debounced, then a direction-detection state machine recognises complete passages. Backed-out, aborted, stalled or malformed sequences are rejected without producing an event.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a filtered sensor changes; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1000: maximum cycles the FSM may remain in one in-progress state; legal range ≥2.

**Ports**
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sensor_outer` in 1: raw, asynchronous; 1 = street-side beam blocked.
- `sensor_inner` in 1: raw, asynchronous; 1 = lot-side beam blocked.
- `car_enter` out 1: one-cycle pulse per completed inbound passage.
- `car_exit` out 1: one-cycle pulse per completed outbound passage.
- `seq_error` out 1: one-cycle pulse on an illegal sequence or timeout.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

**Synchroniser and debounce**
- Each sensor passes through a 2-flop synchroniser, then a debouncer.
- The debounce counter increments on every edge where the synchronised value differs from the filtered value, and clears on every edge where they agree.
- On the edge where the counter reaches `DEBOUNCE_CYCLES`, the filtered value takes the synchronised value and the counter clears.

**FSM**
- Input is the filtered pair `(o,i)`.
- States: IDLE, IN_1, IN_2, IN_3, OUT_1, OUT_2, OUT_3, ERR.

**Transitions from IDLE**
- (1,0) → IN_1
- (0,1) → OUT_1
- (1,1) → ERR with `seq_error`

**Inbound states**
- IN_1: (1,1) → IN_2; (0,1) → IN_3; (0,0) → IDLE with no pulse (car backed out).
- IN_2: (0,1) → IN_3; (1,0) → IN_1; (0,0) → ERR with `seq_error`.
- IN_3: (0,0) → IDLE with `car_enter`; (1,1) → IN_2; (1,0) → ERR with `seq_error`.

**Outbound states**
- OUT_1..OUT_3 mirror IN_1..IN_3 with outer and inner swapped.
- OUT_3 → IDLE on (0,0) issues `car_exit`.

**ERR**
- Stays in ERR until (0,0), then → IDLE.
- No pulses while in ERR; the timeout is inactive in ERR.

**Timeout**
- A counter runs in IN_x and OUT_x and clears on every state change.
- On the edge where it would reach `TIMEOUT_CYCLES`, the FSM → ERR and `seq_error` pulses.
- If a legal transition occurs on that same edge, the legal transition wins.

**Output rules**
- At most one of `car_enter`, `car_exit`, `seq_error` is high in any cycle.
- Each is high for exactly one cycle per event.

**Reset values**
- Synchroniser flops, filtered values and counters = 0.
- State = IDLE.
- `car_enter`, `car_exit`, `seq_error`, `busy` = 0.

**Reset mid-operation**
- Aborts any in-progress passage silently, with no pulse.
- A beam still blocked after reset release is debounced afresh and treated as a new arrival.

## Timing

- All outputs are registered; none is combinational from inputs.
- Latency: a raw sensor change first sampled at edge 0 reaches the filtered value at edge `DEBOUNCE_CYCLES`+1. The resulting FSM transition and any pulse register at edge `DEBOUNCE_CYCLES`+2, so the pulse is high during the following cycle. With default parameters that is edge 6.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles are ignored entirely.
- `busy` updates on the same edge as the state register.
- There is no back-pressure: the downstream counter must accept a pulse on any cycle.

## Structure

- Shared package `parking_pkg` holds:
  - `gate_state_t`, the enum of the eight states;
  - localparams for the sensor-pair encodings (`CLEAR`, `OUTER_ONLY`, `INNER_ONLY`, `BOTH`).
- Counter widths are derived with `$clog2` inside the module.
- One sub-module, `sensor_debounce`, contains the 2-flop synchroniser plus the debounce counter for one sensor, parameterised by `DEBOUNCE_CYCLES`. It is instantiated twice.
- The FSM, timeout counter and output registers live in `parking_gate_detector`.

## Test plan

1. **Clean entry.** With defaults, drive raw sequence (1,0) → (1,1) → (0,1) → (0,0), each held 10 cycles. Expect exactly one `car_enter` pulse, 6 edges after the final change, and no `car_exit` or `seq_error`.
2. **Clean exit.** Drive the mirror sequence (0,1) → (1,1) → (1,0) → (0,0). Expect exactly one `car_exit` pulse; `busy` high from the first filtered change until the pulse edge.
3. **Glitch rejection and backed-out car.**
   - A 3-cycle pulse on `sensor_outer` produces no state change and `busy` stays 0.
   - The sequence (1,0) → (0,0) produces `busy` then a return to IDLE with no pulses.
4. **Illegal sequence.**
   - (1,1) arriving from IDLE gives `seq_error` and ERR.
   - `busy` stays high until (0,0) is held 4 cycles.
   - A following clean entry then yields `car_enter`.
5. **Timeout.** With `TIMEOUT_CYCLES`=20, hold (1,0). Expect `seq_error` exactly 20 cycles after entering IN_1 and the FSM in ERR; releasing to (0,0) returns to IDLE with no `car_enter`.
6. **Reset mid-passage.** Assert `reset` asynchronously while in IN_3. All outputs are 0 immediately, and no `car_enter` is issued when (0,0) later arrives.
